// File: rtl/rs_sipo_framer.sv
// -----------------------------------------------------------------------------
// rs_sipo_framer
//
// Sequencing controller for the serial-to-parallel front end of the
// Reed-Solomon receive path. Tracks bit and symbol position inside a serial
// codeword and pulses sipo_enable_o on the last bit of every symbol. Each
// symbol the SIPO returns is tagged with start/end-of-codeword markers and
// buffered in a 4-entry FIFO, which feeds the decoder over valid/ready.
//
// Parameters
//   SYM_W  symbol width in bits (>= 2)
//   N_SYM  symbols per codeword (>= 2)
//   CNT_W  symbol counter width (2**CNT_W >= N_SYM)
//
// Ports
//   clk                clock
//   rst                asynchronous, active-high reset
//   start_i            one-cycle pulse: bit 0 of a codeword is on the SIPO input
//   sipo_enable_o      to SIPO enable; one-cycle pulse on the last bit of a symbol
//   sipo_data_i        from SIPO data_out
//   sipo_data_valid_i  from SIPO data_valid; pushes a symbol into the FIFO
//   sym_data_o         FIFO head symbol (0 when empty)
//   sym_sof_o          head symbol is symbol 0 of its codeword
//   sym_eof_o          head symbol is symbol N_SYM-1 of its codeword
//   sym_valid_o        FIFO non-empty
//   sym_ready_i        downstream accepts the head symbol
//   busy_o             high while receiving a codeword
//   overflow_o         sticky: a symbol was dropped on a full FIFO
//   frame_err_o        one-cycle pulse: a codeword was cut short by a resync
// -----------------------------------------------------------------------------
module rs_sipo_framer #(
    parameter int SYM_W = 8,
    parameter int N_SYM = 255,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    output logic             sipo_enable_o,
    input  logic [SYM_W-1:0] sipo_data_i,
    input  logic             sipo_data_valid_i,
    output logic [SYM_W-1:0] sym_data_o,
    output logic             sym_sof_o,
    output logic             sym_eof_o,
    output logic             sym_valid_o,
    input  logic             sym_ready_i,
    output logic             busy_o,
    output logic             overflow_o,
    output logic             frame_err_o
);

    localparam int BIT_W   = (SYM_W > 1) ? $clog2(SYM_W) : 1;
    localparam int ENTRY_W = SYM_W + 2;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SYM_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [CNT_W-1:0] SYM_LAST = CNT_W'(N_SYM - 1);
    localparam logic [CNT_W-1:0] SYM_ONE  = CNT_W'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    // ---------------------------------------------------------------------
    // Bit / symbol sequencer
    // ---------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic             pend_sof_q, pend_eof_q;
    logic             frame_err_q;

    logic last_bit;
    logic final_en;
    logic resync;

    assign last_bit = (state_q == S_RECV) && (bit_cnt_q == BIT_LAST);
    assign final_en = last_bit && (sym_cnt_q == SYM_LAST);
    // The final enable cycle carries a data bit, so a start there is ignored.
    assign resync   = (state_q == S_RECV) && start_i && !final_en;

    // A resync restarts the codeword on this very cycle, so the symbol in
    // flight is abandoned and no enable is issued for it.
    assign sipo_enable_o = last_bit && !resync;
    assign busy_o        = (state_q == S_RECV);
    assign frame_err_o   = frame_err_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sym_cnt_d = sym_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_RECV;
                    bit_cnt_d = BIT_ONE;
                    sym_cnt_d = '0;
                end
            end
            S_RECV: begin
                if (resync) begin
                    bit_cnt_d = BIT_ONE;
                    sym_cnt_d = '0;
                end else if (last_bit) begin
                    bit_cnt_d = '0;
                    if (final_en) begin
                        state_d   = S_IDLE;
                        sym_cnt_d = '0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + SYM_ONE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_ONE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                bit_cnt_d = '0;
                sym_cnt_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            sym_cnt_q   <= '0;
            pend_sof_q  <= 1'b0;
            pend_eof_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sym_cnt_q   <= sym_cnt_d;
            frame_err_q <= resync;
            // The SIPO answers one cycle after the enable; hold the tag until
            // then. A later resync leaves it intact for the symbol in flight.
            if (sipo_enable_o) begin
                pend_sof_q <= (sym_cnt_q == '0);
                pend_eof_q <= (sym_cnt_q == SYM_LAST);
            end
        end
    end

    // ---------------------------------------------------------------------
    // 4-entry symbol FIFO
    // ---------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem_q [4];
    logic [1:0]         wr_ptr_q, rd_ptr_q;
    logic [2:0]         count_q, count_d;
    logic               overflow_q;

    logic               fifo_empty, fifo_full;
    logic               pop, push_ok, drop;
    logic [ENTRY_W-1:0] head;

    assign fifo_empty = (count_q == 3'd0);
    assign fifo_full  = (count_q == 3'd4);
    assign pop        = !fifo_empty && sym_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok    = sipo_data_valid_i && (!fifo_full || pop);
    assign drop       = sipo_data_valid_i && fifo_full && !pop;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 2'd1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 2'd1;
            // A fresh drop wins over the clear from a start in IDLE.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if ((state_q == S_IDLE) && start_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; the pointers and occupancy are
    // reset, and the outputs are masked while empty, so stale contents are
    // never visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {sipo_data_i, pend_sof_q, pend_eof_q};
        end
    end

    assign head        = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign sym_data_o  = head[ENTRY_W-1:2];
    assign sym_sof_o   = head[1];
    assign sym_eof_o   = head[0];
    assign sym_valid_o = !fifo_empty;
    assign overflow_o  = overflow_q;

endmodule

// File: doc/rs_sipo_framer.md
# rs_sipo_framer

Sequencing controller for the serial-to-parallel front end of the Reed-Solomon receive path. It tracks bit and symbol position within an incoming serial codeword and generates the one-cycle `sipo_enable` pulses that make the SIPO emit each SYM_W-bit symbol. Each symbol the SIPO returns is tagged with start/end-of-codeword markers and buffered in a 4-entry FIFO. The FIFO feeds the decoder through a valid/ready handshake and reports overflow and framing errors.

## Interface
- SYM_W, 8: symbol width in bits; must be ≥ 2.
- N_SYM, 255: symbols per codeword; must be ≥ 2.
- CNT_W, 8: symbol counter width; must satisfy 2^CNT_W ≥ N_SYM.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle pulse; marks the cycle in which bit 0 of a codeword is on the SIPO serial input.
- sipo_enable  out  1  to SIPO `enable`; one-cycle pulse on the last bit of each symbol.
- sipo_data  in  SYM_W  from SIPO `data_out`.
- sipo_data_valid  in  1  from SIPO `data_valid`.
- sym_data  out  SYM_W  FIFO head symbol.
- sym_sof  out  1  head symbol is symbol 0 of its codeword.
- sym_eof  out  1  head symbol is symbol N_SYM-1 of its codeword.
- sym_valid  out  1  FIFO non-empty.
- sym_ready  in  1  downstream accepts the head; a pop occurs when `sym_valid` and `sym_ready` are both high.
- busy  out  1  high while state is RECV.
- overflow  out  1  sticky; a symbol was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse; a codeword was cut short by a resync.

## Operation
- States: IDLE and RECV. Counters: `bit_cnt` (0..SYM_W-1) and `sym_cnt` (0..N_SYM-1).
- IDLE:
  - `start` → RECV with `bit_cnt`=1 and `sym_cnt`=0.
  - The same `start` clears `overflow` unless a new overflow occurs in that same cycle.
- RECV, each cycle:
  - If `bit_cnt`==SYM_W-1: assert `sipo_enable`, record the tag (sof = `sym_cnt`==0, eof = `sym_cnt`==N_SYM-1) into a one-deep pending-tag register, set `bit_cnt`=0, and increment `sym_cnt`.
  - Otherwise increment `bit_cnt`.
  - On the eof enable cycle, go to IDLE next cycle.
- Resync: `start` in RECV on any cycle other than the final enable cycle:
  - pulse `frame_err` the next cycle;
  - restart counters exactly as a start from IDLE;
  - issue no `sipo_enable` that cycle.
  - The partial codeword never receives an eof-tagged symbol.
- `start` on the final enable cycle of RECV is ignored. That cycle carries a data bit, so it cannot be bit 0 of a new codeword.
- Push: `sipo_data_valid` writes {`sipo_data`, pending sof, pending eof} into the FIFO.
  - A symbol whose enable was issued before a resync is still pushed with its original tag.
- FIFO: depth 4, with 3-bit occupancy. `sym_*` outputs show the head entry combinationally from the storage array; they are 0 when empty.
- Full FIFO:
  - A push without a simultaneous pop drops the symbol and sets `overflow`.
  - A push with a simultaneous pop succeeds and occupancy stays 4.
- Empty FIFO: no pop occurs. A push makes the symbol visible the following cycle; there is no bypass.
- The serial stream is never stalled. `sym_ready` affects only the FIFO.

## Timing
- Reset values: `sipo_enable`, `busy`, `sym_valid`, `sym_sof`, `sym_eof`, `overflow`, `frame_err` all 0; `sym_data` 0. State IDLE, counters 0, FIFO empty.
- Rst asserted mid-codeword: immediate return to IDLE, FIFO flushed, pending tag cleared.
- With `start` at cycle t0:
  - `sipo_enable` is high at t0+k·SYM_W-1 for k = 1..N_SYM.
  - `sipo_data_valid` arrives one cycle later; the push happens that cycle.
  - `sym_valid` rises at t0+k·SYM_W+1 when the FIFO was empty.
- `busy` is high from t0+1 through the final enable cycle t0+N_SYM·SYM_W-1.
  - Back-to-back codewords: `start` at t0+N_SYM·SYM_W, the first IDLE cycle, is accepted with no lost bit.
- `sipo_enable` pulses are always separated by at least SYM_W-1 low cycles. This guarantees a rising edge at the SIPO each time.
- `frame_err` pulses at tstart+1 on a resync.
- `overflow` sets in the cycle after the dropped push.

## Test plan
- Bench parameters: SYM_W=8, N_SYM=4.
- Single codeword, `sym_ready`=1, serial bytes 0xA5, 0x3C, 0xFF, 0x01 MSB-first from t0:
  - `sipo_enable` high at t0+7, +15, +23, +31;
  - the four symbols appear in order, sof only on 0xA5 and eof only on 0x01;
  - `busy` falls at t0+32.
- Back-to-back codewords, second `start` at t0+32: 8 symbols out, exactly 2 sof and 2 eof, no `frame_err`.
- `sym_ready`=0 for a whole codeword, then 1: 4 symbols delivered intact, `overflow`=0.
- Then `sym_ready`=0 across two codewords: the 5th symbol is dropped and `overflow`=1; the next `start` in IDLE clears it.
- Resync: `start` at t0+12 during a codeword:
  - `frame_err` pulses at t0+13;
  - the first symbol (sof) is delivered and no eof follows it;
  - the new codeword then completes normally with enables at t0+19, +27, +35, +43.
- Rst asserted at t0+20 with 2 symbols buffered: all outputs 0 immediately, `sym_valid`=0, no further `sipo_enable`.
